// File: rtl/exc_pkg.sv
// Shared encodings for the exception vector fetch sequencer: address-mux
// selects, cause codes and sequencer states.
package exc_pkg;

  localparam logic [2:0] SEL_IORD    = 3'b000;
  localparam logic [2:0] SEL_VEC_OPC = 3'b001;
  localparam logic [2:0] SEL_VEC_OVF = 3'b010;
  localparam logic [2:0] SEL_VEC_DIV = 3'b011;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'b00,
    CAUSE_OPC  = 2'b01,
    CAUSE_OVF  = 2'b10,
    CAUSE_DIV  = 2'b11
  } cause_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_WAIT = 2'b10,
    ST_CAPT = 2'b11
  } state_e;

  // Lowest flag index wins: invalid opcode > overflow > divide-by-zero.
  function automatic cause_e prio_cause(input logic [2:0] flags);
    if (flags[0])      return CAUSE_OPC;
    else if (flags[1]) return CAUSE_OVF;
    else if (flags[2]) return CAUSE_DIV;
    else               return CAUSE_NONE;
  endfunction

  function automatic logic [2:0] vec_sel(input cause_e cause);
    case (cause)
      CAUSE_OPC: return SEL_VEC_OPC;
      CAUSE_OVF: return SEL_VEC_OVF;
      CAUSE_DIV: return SEL_VEC_DIV;
      default:   return SEL_IORD;
    endcase
  endfunction

endpackage

// File: rtl/exc_vector_fetch.sv
// Exception sequencer: steers the memory address mux to the vector byte,
// waits out read latency, then strobes the handler address into PC and EPC.
module exc_vector_fetch
  import exc_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 2  // legal range 1..15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  exc_flags,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_data_in,
  output logic [2:0]  srcaddr_sel,
  output logic        busy,
  output logic [31:0] pc_out,
  output logic        pc_we,
  output logic [31:0] epc_out,
  output logic        epc_we,
  output logic [1:0]  cause_out
);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  cause_e      cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] pc_q, pc_d;
  logic        we_q, we_d;

  // Only the vector byte of the read word is ever consumed.
  logic unused_mem_hi;
  assign unused_mem_hi = ^mem_data_in[31:8];

  // NOTE: reset is synchronous, so it lives inside the clocked branch, not the sensitivity list.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cause_q <= CAUSE_NONE;
      epc_q   <= '0;
      pc_q    <= '0;
      we_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
      pc_q    <= pc_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    // NOTE: hold-by-default on every target keeps this block free of inferred latches.
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    epc_d   = epc_q;
    pc_d    = pc_q;
    we_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|exc_flags) begin
          cause_d = prio_cause(exc_flags);
          epc_d   = pc_in - 32'd4;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        cnt_d   = 4'(MEM_LATENCY - 1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          // Strobe is registered here so it is high exactly while in CAPT.
          pc_d    = {24'b0, mem_data_in[7:0]};
          we_d    = 1'b1;
          state_d = ST_CAPT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_CAPT: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign srcaddr_sel = (state_q == ST_IDLE) ? SEL_IORD : vec_sel(cause_q);
  assign busy        = (state_q != ST_IDLE);
  assign pc_out      = pc_q;
  assign pc_we       = we_q;
  assign epc_out     = epc_q;
  assign epc_we      = we_q;
  assign cause_out   = cause_q;

endmodule

// File: tb/tb_exc_vector_fetch.sv
// Bench for exc_vector_fetch: two instances (latency 2 and 1) share stimulus
// and are checked each cycle against a timeline model of the exception sequence.
module tb_exc_vector_fetch;

  localparam int LAT_A = 2;
  localparam int LAT_B = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  exc_flags;
  logic [31:0] pc_in;
  logic [31:0] mem_a, mem_b;
  logic [2:0]  sel_a, sel_b;
  logic        busy_a, busy_b, pc_we_a, pc_we_b, epc_we_a, epc_we_b;
  logic [31:0] pc_out_a, pc_out_b, epc_out_a, epc_out_b;
  logic [1:0]  cause_a, cause_b;

  int n_checks = 0;
  int n_errors = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  exc_vector_fetch #(.MEM_LATENCY(LAT_A)) dut_a (
    .clk(clk), .reset(reset), .exc_flags(exc_flags), .pc_in(pc_in),
    .mem_data_in(mem_a), .srcaddr_sel(sel_a), .busy(busy_a),
    .pc_out(pc_out_a), .pc_we(pc_we_a), .epc_out(epc_out_a),
    .epc_we(epc_we_a), .cause_out(cause_a)
  );

  exc_vector_fetch #(.MEM_LATENCY(LAT_B)) dut_b (
    .clk(clk), .reset(reset), .exc_flags(exc_flags), .pc_in(pc_in),
    .mem_data_in(mem_b), .srcaddr_sel(sel_b), .busy(busy_b),
    .pc_out(pc_out_b), .pc_we(pc_we_b), .epc_out(epc_out_b),
    .epc_we(epc_we_b), .cause_out(cause_b)
  );

  // Memory: bytes 253/254/255 hold vec[0..2]; anything else reads as noise.
  logic [7:0]  vec [3];
  logic [23:0] noise;
  logic [31:0] pipe_a;

  function automatic logic [31:0] lookup(input logic [2:0] sel, input logic [23:0] nz);
    case (sel)
      3'b001:  return {nz, vec[0]};
      3'b010:  return {nz, vec[1]};
      3'b011:  return {nz, vec[2]};
      default: return {nz, nz[7:0] ^ 8'h5A};
    endcase
  endfunction

  always @(posedge clk) begin
    noise  <= 24'($urandom);
    pipe_a <= lookup(sel_a, noise);   // one register stage = latency 2
  end
  assign mem_a = pipe_a;
  assign mem_b = lookup(sel_b, noise); // combinational = latency 1

  // Timeline model: m_pos counts cycles since acceptance (0 = idle);
  // the sequence occupies cycles 1..lat+2 and strobes in the last one.
  int          m_pos   [2];
  logic [1:0]  m_cause [2];
  logic [31:0] m_epc   [2];
  logic [31:0] m_pc    [2];

  function automatic int lat_of(input int d);
    return (d == 0) ? LAT_A : LAT_B;
  endfunction

  function automatic logic [2:0] exp_sel(input logic [1:0] c);
    case (c)
      2'd1:    return 3'b001;
      2'd2:    return 3'b010;
      2'd3:    return 3'b011;
      default: return 3'b000;
    endcase
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        m_pos[d] = 0; m_cause[d] = 2'd0; m_epc[d] = 32'd0; m_pc[d] = 32'd0;
      end else if (m_pos[d] == 0) begin
        if (exc_flags != 3'b000) begin
          m_cause[d] = exc_flags[0] ? 2'd1 : (exc_flags[1] ? 2'd2 : 2'd3);
          m_epc[d]   = pc_in - 32'd4;
          m_pos[d]   = 1;
        end
      end else if (m_pos[d] == lat_of(d) + 2) begin
        m_pos[d] = 0;
      end else begin
        m_pos[d] = m_pos[d] + 1;
        if (m_pos[d] == lat_of(d) + 2) m_pc[d] = {24'b0, vec[m_cause[d] - 2'd1]};
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_dut(input int d, input logic [2:0] sel, input logic bsy,
                           input logic pwe, input logic ewe, input logic [31:0] pco,
                           input logic [31:0] epc, input logic [1:0] cause);
    logic strobe;
    strobe = (m_pos[d] == lat_of(d) + 2);
    check($sformatf("d%0d_sel", d),    32'(sel),   32'(m_pos[d] != 0 ? exp_sel(m_cause[d]) : 3'b000));
    check($sformatf("d%0d_busy", d),   32'(bsy),   32'(m_pos[d] != 0));
    check($sformatf("d%0d_pc_we", d),  32'(pwe),   32'(strobe));
    check($sformatf("d%0d_epc_we", d), 32'(ewe),   32'(strobe));
    check($sformatf("d%0d_pc_out", d), pco,        m_pc[d]);
    check($sformatf("d%0d_epc", d),    epc,        m_epc[d]);
    check($sformatf("d%0d_cause", d),  32'(cause), 32'(m_cause[d]));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check_dut(0, sel_a, busy_a, pc_we_a, epc_we_a, pc_out_a, epc_out_a, cause_a);
      check_dut(1, sel_b, busy_b, pc_we_b, epc_we_b, pc_out_b, epc_out_b, cause_b);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Pulse flags for one acceptance edge, then observe 8 cycles.
  task automatic fire(input logic [2:0] f, input logic [31:0] pc,
                      output int bn_a, output int we_a, output int bn_b, output int we_b);
    bn_a = 0; we_a = 0; bn_b = 0; we_b = 0;
    step(); exc_flags = f; pc_in = pc;
    step(); exc_flags = 3'b000; pc_in = $urandom;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (busy_a) bn_a++;
      if (busy_b) bn_b++;
      if (pc_we_a) we_a = i;
      if (pc_we_b) we_b = i;
      step();
    end
  endtask

  initial begin
    int bn_a, we_a, bn_b, we_b, any_we;
    reset = 1'b1; exc_flags = 3'b000; pc_in = 32'h0;
    vec[0] = 8'h7C; vec[1] = 8'h20; vec[2] = 8'hE3;
    step(); chk_en = 1'b1;
    step();
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_sel_a", 32'(sel_a), 32'd0);
    check("rst_pc_out_b", pc_out_b, 32'd0);
    check("rst_cause_b", 32'(cause_b), 32'd0);
    reset = 1'b0;
    step();

    // Invalid opcode, vector 253.
    fire(3'b001, 32'h40, bn_a, we_a, bn_b, we_b);
    check("t1_pc_out_a", pc_out_a, 32'h7C);
    check("t1_epc_a", epc_out_a, 32'h3C);
    check("t1_cause_a", 32'(cause_a), 32'd1);
    check("t1_busy_cycles_a", 32'(bn_a), 32'd4);
    check("t1_we_cycle_a", 32'(we_a), 32'd4);
    check("t1_busy_cycles_b", 32'(bn_b), 32'd3);
    check("t1_we_cycle_b", 32'(we_b), 32'd3);
    check("t1_sel_after_a", 32'(sel_a), 32'd0);

    // Overflow beats divide-by-zero.
    fire(3'b110, 32'h1000, bn_a, we_a, bn_b, we_b);
    check("t2_pc_out_a", pc_out_a, 32'h20);
    check("t2_cause_a", 32'(cause_a), 32'd2);
    check("t2_pc_out_b", pc_out_b, 32'h20);

    // EPC wraps below zero; latency-1 instance strobes on 3rd cycle.
    fire(3'b010, 32'h0, bn_a, we_a, bn_b, we_b);
    check("t6_epc_a", epc_out_a, 32'hFFFF_FFFC);
    check("t6_epc_b", epc_out_b, 32'hFFFF_FFFC);
    check("t6_we_cycle_b", 32'(we_b), 32'd3);

    // Flags toggled while busy are ignored.
    step(); exc_flags = 3'b100; pc_in = 32'h200;
    step(); exc_flags = 3'b000;
    step(); exc_flags = 3'b001;
    step(); exc_flags = 3'b000;
    repeat (6) step();
    check("t5_cause_a", 32'(cause_a), 32'd3);
    check("t5_pc_out_a", pc_out_a, 32'hE3);
    check("t5_cause_b", 32'(cause_b), 32'd3);
    check("t5_epc_b", epc_out_b, 32'h1FC);

    // Reset in WAIT: outputs clear and no strobe follows.
    step(); exc_flags = 3'b010; pc_in = 32'h300;
    step(); exc_flags = 3'b000;
    step(); reset = 1'b1;
    step(); reset = 1'b0;
    @(negedge clk);
    check("t4_busy_a", 32'(busy_a), 32'd0);
    check("t4_sel_a", 32'(sel_a), 32'd0);
    check("t4_pc_out_a", pc_out_a, 32'd0);
    check("t4_epc_a", epc_out_a, 32'd0);
    check("t4_cause_b", 32'(cause_b), 32'd0);
    any_we = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      @(negedge clk);
      if (pc_we_a || pc_we_b || epc_we_a || epc_we_b) any_we = 1;
    end
    check("t4_no_strobe", 32'(any_we), 32'd0);
    step();

    // Randomized traffic against the model.
    vec[0] = 8'($urandom); vec[1] = 8'($urandom); vec[2] = 8'($urandom);
    for (int i = 0; i < 600; i++) begin
      exc_flags = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      pc_in     = $urandom;
      reset     = ($urandom_range(0, 79) == 0);
      step();
    end
    reset = 1'b0; exc_flags = 3'b000;
    repeat (8) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
